// File: rtl/pipe_ex_mem.sv
// EX/MEM pipeline register: holds its entry while data memory is busy, turns
// flushed entries into NOP bubbles, freezes on halt, and flags memory timeouts.
module pipe_ex_mem #(
    parameter logic [7:0] STALL_TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ALU_result,
    input  logic [15:0] Data_two,
    input  logic [15:0] bj_write_data,
    input  logic [15:0] instruction,
    input  logic [2:0]  write_sel,
    input  logic        Reg_write,
    input  logic        Mem_read,
    input  logic        Mem_write,
    input  logic        Mem_reg,
    input  logic        Mem_en,
    input  logic        JAL,
    input  logic        halt,
    input  logic        valid_rd,
    input  logic        flush,
    input  logic        mem_stall,
    output logic [15:0] ALU_result_o,
    output logic [15:0] Data_two_o,
    output logic [15:0] bj_write_data_o,
    output logic [15:0] instruction_o,
    output logic [2:0]  write_sel_o,
    output logic        Reg_write_o,
    output logic        Mem_read_o,
    output logic        Mem_write_o,
    output logic        Mem_reg_o,
    output logic        Mem_en_o,
    output logic        JAL_o,
    output logic        halt_o,
    output logic        valid_rd_o,
    output logic        valid_o,
    output logic        stall_o,
    output logic        err_o
);
    localparam logic [15:0] NOP = 16'h0800;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        WAIT   = 2'd1,
        HALTED = 2'd2
    } state_t;

    typedef struct packed {
        logic [15:0] alu_result;
        logic [15:0] data_two;
        logic [15:0] bj_write_data;
        logic [15:0] instruction;
        logic [2:0]  write_sel;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_reg;
        logic        mem_en;
        logic        jal;
        logic        halt;
        logic        valid_rd;
        logic        valid;
    } entry_t;

    localparam entry_t ENTRY_RST = '{instruction: NOP, default: '0};

    state_t      state_q, state_d;
    entry_t      ent_q, ent_d, ent_in;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        mem_hold;
    logic        halt_take;

    // Incoming EX entry, already converted to a bubble when flushed.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        ent_in = '{
            alu_result:    ALU_result,
            data_two:      Data_two,
            bj_write_data: bj_write_data,
            instruction:   instruction,
            write_sel:     write_sel,
            reg_write:     Reg_write,
            mem_read:      Mem_read,
            mem_write:     Mem_write,
            mem_reg:       Mem_reg,
            mem_en:        Mem_en,
            jal:           JAL,
            halt:          halt,
            valid_rd:      valid_rd,
            valid:         1'b1
        };
        if (flush) begin
            ent_in.instruction = NOP;
            ent_in.reg_write   = 1'b0;
            ent_in.mem_read    = 1'b0;
            ent_in.mem_write   = 1'b0;
            ent_in.mem_en      = 1'b0;
            ent_in.halt        = 1'b0;
            ent_in.jal         = 1'b0;
            ent_in.valid_rd    = 1'b0;
            ent_in.valid       = 1'b0;
        end
    end

    // mem_stall only matters when the held entry is a real memory access.
    assign mem_hold  = (state_q == RUN) && mem_stall && ent_q.mem_en && ent_q.valid;
    assign halt_take = (state_q == RUN) && ent_q.halt && ent_q.valid;

    always_comb begin
        state_d = state_q;
        ent_d   = ent_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            RUN: begin
                if (mem_hold) begin
                    state_d = WAIT;
                    cnt_d   = 8'd1;
                end else if (halt_take) begin
                    // Keep the halt entry in place so halt_o stays visible while frozen.
                    state_d = HALTED;
                end else begin
                    ent_d = ent_in;
                end
            end
            WAIT: begin
                if (cnt_q == STALL_TIMEOUT) err_d = 1'b1;
                if (!mem_stall) begin
                    state_d = RUN;
                    cnt_d   = 8'd0;
                end else if (cnt_q < STALL_TIMEOUT) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst) begin
            state_q <= RUN;
            ent_q   <= ENTRY_RST;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ent_q   <= ent_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign ALU_result_o    = ent_q.alu_result;
    assign Data_two_o      = ent_q.data_two;
    assign bj_write_data_o = ent_q.bj_write_data;
    assign instruction_o   = ent_q.instruction;
    assign write_sel_o     = ent_q.write_sel;
    assign Reg_write_o     = ent_q.reg_write;
    assign Mem_read_o      = ent_q.mem_read;
    assign Mem_write_o     = ent_q.mem_write;
    assign Mem_reg_o       = ent_q.mem_reg;
    assign Mem_en_o        = ent_q.mem_en;
    assign JAL_o           = ent_q.jal;
    assign halt_o          = ent_q.halt;
    assign valid_rd_o      = ent_q.valid_rd;
    assign valid_o         = ent_q.valid;
    assign err_o           = err_q;
    assign stall_o         = (state_q == WAIT) || mem_hold || (state_q == HALTED);

endmodule
